// File: rtl/irq_request_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_request_ctrl_if
// Description : Interrupt request / service handshake between the request
//               controller (master) and the PC interrupt-sequencing block
//               (slave). Requests flow master->slave; running levels and
//               one-cycle done pulses flow back.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_request_ctrl_if;
  logic interrupt1;
  logic interrupt2;
  logic interrupt3;
  logic interrupt1_running;
  logic interrupt2_running;
  logic interrupt3_running;
  logic interrupt1_done;
  logic interrupt2_done;
  logic interrupt3_done;

  // Request controller side
  modport master (
    output interrupt1, interrupt2, interrupt3,
    input  interrupt1_running, interrupt2_running, interrupt3_running,
    input  interrupt1_done, interrupt2_done, interrupt3_done
  );

  // PC / sequencer side
  modport slave (
    input  interrupt1, interrupt2, interrupt3,
    output interrupt1_running, interrupt2_running, interrupt3_running,
    output interrupt1_done, interrupt2_done, interrupt3_done
  );
endinterface
`default_nettype wire

// File: rtl/irq_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_request_ctrl
// Description : Initiator side of the CPU interrupt handshake. Synchronises
//               three raw request lines, captures rising edges into pending
//               latches, gates them by mask and nesting state into registered
//               interrupt1..3 levels, retires them on the running edge, flags
//               lost requests and counts serviced interrupts.
//               Optional feature macro: IRQ_TIMEOUT_EN (per-level request
//               timeout with sticky flag and forced pending clear).
// Revision    : 1.0 - initial release
// ============================================================================
module irq_request_ctrl #(
  parameter int SYNC_STAGES = 2,     // must be >= 2
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  wire logic             clk,
  input  wire logic             clr_n,
  input  wire logic [2:0]       irq_src,
  input  wire logic [2:0]       irq_mask,
  input  wire logic             lost_clr,
  irq_request_ctrl_if.master    pc_if,
  output logic      [2:0]       pending,
  output logic      [2:0]       lost,
  output logic      [1:0]       active_level,
  output logic      [CNT_W-1:0] serviced_cnt,
  output logic      [2:0]       irq_timeout
);

  logic [2:0]       r_sync [SYNC_STAGES];
  logic [2:0]       r_sync_d;
  logic [2:0]       r_run_d;
  logic [2:0]       r_pending;
  logic [2:0]       r_lost;
  logic [2:0]       r_int;
  logic [1:0]       r_active;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_run;
  logic [2:0]       w_done;
  logic [2:0]       w_rise;
  logic [2:0]       w_ack;
  logic [2:0]       w_tmo_hit;
  logic [2:0]       w_gate;
  logic [2:0]       w_pending_nxt;
  logic [2:0]       w_lost_nxt;
  logic [1:0]       w_pop;

  assign w_run  = {pc_if.interrupt3_running, pc_if.interrupt2_running, pc_if.interrupt1_running};
  assign w_done = {pc_if.interrupt3_done, pc_if.interrupt2_done, pc_if.interrupt1_done};

  // Synchroniser chain plus one extra stage for rising-edge detection
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'b000;
      r_sync_d <= 3'b000;
    end else begin
      r_sync[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

  // Delayed running levels; an acknowledge is the rising edge of running
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_run_d <= 3'b000;
    else        r_run_d <= w_run;
  end

  assign w_ack = w_run & ~r_run_d;

  // A new request wins over a same-cycle ack or timeout; lost only counts
  // a second edge that nobody acknowledged, and setting beats lost_clr.
  assign w_pending_nxt = w_rise | (r_pending & ~(w_ack | w_tmo_hit));
  assign w_lost_nxt    = (w_rise & r_pending & ~w_ack) | (r_lost & ~{3{lost_clr}});

  // Pending and lost latches
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pending <= 3'b000;
      r_lost    <= 3'b000;
    end else begin
      r_pending <= w_pending_nxt;
      r_lost    <= w_lost_nxt;
    end
  end

  // Level 3 is highest priority: a running level blocks itself and all lower
  assign w_gate[2] = r_pending[2] & ~irq_mask[2] & ~w_run[2];
  assign w_gate[1] = r_pending[1] & ~irq_mask[1] & ~w_run[1] & ~w_run[2];
  assign w_gate[0] = r_pending[0] & ~irq_mask[0] & ~w_run[0] & ~w_run[1] & ~w_run[2];

  // Registered request levels presented to the PC
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_int <= 3'b000;
    else        r_int <= w_gate;
  end

  // Highest level currently in service (0 = user code)
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)        r_active <= 2'd0;
    else if (w_run[2]) r_active <= 2'd3;
    else if (w_run[1]) r_active <= 2'd2;
    else if (w_run[0]) r_active <= 2'd1;
    else               r_active <= 2'd0;
  end

  assign w_pop = 2'(w_done[0]) + 2'(w_done[1]) + 2'(w_done[2]);

  // Serviced-interrupt counter, wraps naturally
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + CNT_W'(w_pop);
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_to_cnt [3];
  logic [2:0]    r_timeout;

  // A level times out after TIMEOUT_CYC consecutive cycles with its request high
  always_comb begin
    w_tmo_hit = 3'b000;
    for (int n = 0; n < 3; n++)
      w_tmo_hit[n] = r_int[n] && (r_to_cnt[n] == TW'(TIMEOUT_CYC - 1));
  end

  // Per-level unacknowledged-request counters and sticky timeout flags
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int n = 0; n < 3; n++) r_to_cnt[n] <= '0;
      r_timeout <= 3'b000;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (!r_int[n] || w_tmo_hit[n]) r_to_cnt[n] <= '0;
        else                           r_to_cnt[n] <= r_to_cnt[n] + 1'b1;
      end
      r_timeout <= w_tmo_hit | (r_timeout & ~{3{lost_clr}});
    end
  end

  assign irq_timeout = r_timeout;
`else
  logic w_unused_timeout;

  assign w_tmo_hit        = 3'b000;
  assign irq_timeout      = 3'b000;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

  assign pc_if.interrupt1 = r_int[0];
  assign pc_if.interrupt2 = r_int[1];
  assign pc_if.interrupt3 = r_int[2];
  assign pending          = r_pending;
  assign lost             = r_lost;
  assign active_level     = r_active;
  assign serviced_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_irq_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_request_ctrl
// Description : Self-checking bench for irq_request_ctrl. Expected latencies
//               and counts are queued when stimulus is applied and compared
//               when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_request_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [2:0]  irq_src = 3'b000;
  logic [2:0]  irq_mask = 3'b000;
  logic        lost_clr = 1'b0;

  logic [2:0]  pending, lost, irq_timeout;
  logic [1:0]  active_level;
  logic [15:0] serviced_cnt;
  logic [2:0]  ints;

  logic [2:0]  pending4, lost4, irq_timeout4;
  logic [1:0]  active_level4;
  logic [3:0]  serviced_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];

  irq_request_ctrl_if pc_if ();
  irq_request_ctrl_if pc4_if ();

  irq_request_ctrl #(.SYNC_STAGES(2), .CNT_W(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .clr_n(clr_n), .irq_src(irq_src), .irq_mask(irq_mask),
    .lost_clr(lost_clr), .pc_if(pc_if), .pending(pending), .lost(lost),
    .active_level(active_level), .serviced_cnt(serviced_cnt),
    .irq_timeout(irq_timeout)
  );

  irq_request_ctrl #(.SYNC_STAGES(2), .CNT_W(4), .TIMEOUT_CYC(8)) dut4 (
    .clk(clk), .clr_n(clr_n), .irq_src(3'b000), .irq_mask(3'b000),
    .lost_clr(1'b0), .pc_if(pc4_if), .pending(pending4), .lost(lost4),
    .active_level(active_level4), .serviced_cnt(serviced_cnt4),
    .irq_timeout(irq_timeout4)
  );

  assign ints = {pc_if.interrupt3, pc_if.interrupt2, pc_if.interrupt1};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int v);
    sb_q.push_back(v);
  endtask

  task automatic sb_pop_check(input string tag, input logic [31:0] obs);
    int e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0h with no expected value queued", tag, obs);
    end else begin
      e = sb_q.pop_front();
      chk_eq(tag, obs, 32'(e));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_run(input logic [2:0] r);
    pc_if.interrupt1_running = r[0];
    pc_if.interrupt2_running = r[1];
    pc_if.interrupt3_running = r[2];
  endtask

  task automatic pulse_done(input logic [2:0] d);
    pc_if.interrupt1_done = d[0];
    pc_if.interrupt2_done = d[1];
    pc_if.interrupt3_done = d[2];
    tick(1);
    pc_if.interrupt1_done = 1'b0;
    pc_if.interrupt2_done = 1'b0;
    pc_if.interrupt3_done = 1'b0;
  endtask

  task automatic pulse_done4();
    pc4_if.interrupt1_done = 1'b1;
    tick(1);
    pc4_if.interrupt1_done = 1'b0;
  endtask

  // Raise irq_src[b], expect the request SYNC_STAGES+2 edges later
  task automatic request_latency(input int b, input string tag);
    int n;
    irq_src[b] = 1'b1;
    sb_push(4);
    n = 0;
    while (!ints[b] && n < 20) begin
      tick(1);
      n++;
    end
    sb_pop_check(tag, 32'(n));
    irq_src[b] = 1'b0;
  endtask

  initial begin
    logic seen;
    int   n;

    set_run(3'b000);
    pc_if.interrupt1_done = 1'b0;
    pc_if.interrupt2_done = 1'b0;
    pc_if.interrupt3_done = 1'b0;
    pc4_if.interrupt1_running = 1'b0;
    pc4_if.interrupt2_running = 1'b0;
    pc4_if.interrupt3_running = 1'b0;
    pc4_if.interrupt1_done = 1'b0;
    pc4_if.interrupt2_done = 1'b0;
    pc4_if.interrupt3_done = 1'b0;

    // Reset state
    tick(3);
    chk_eq("rst_pending", 32'(pending), 0);
    chk_eq("rst_lost", 32'(lost), 0);
    chk_eq("rst_ints", 32'(ints), 0);
    chk_eq("rst_active", 32'(active_level), 0);
    chk_eq("rst_cnt", 32'(serviced_cnt), 0);
    chk_eq("rst_tmo", 32'(irq_timeout), 0);
    clr_n = 1'b1;
    tick(2);

    // Basic request and acknowledge on level 1
    request_latency(0, "lat_int1");
    chk_eq("pend_l1", 32'(pending), 1);
    tick(5);
    chk_eq("int1_held", 32'(ints), 1);
    set_run(3'b001);
    tick(1);
    chk_eq("ack1_ints", 32'(ints), 0);
    chk_eq("ack1_pend", 32'(pending), 0);
    chk_eq("ack1_active", 32'(active_level), 1);

    // Nesting: level 3 over level 1, level 2 blocked by running 3
    request_latency(2, "lat_int3");
    set_run(3'b101);
    tick(1);
    chk_eq("ack3_ints", 32'(ints), 0);
    chk_eq("ack3_active", 32'(active_level), 3);
    irq_src[1] = 1'b1;
    tick(3);
    irq_src[1] = 1'b0;
    tick(5);
    chk_eq("int2_blocked", 32'(ints), 0);
    chk_eq("int2_pend", 32'(pending), 2);
    set_run(3'b001);
    tick(1);
    chk_eq("int2_after_run3", 32'(ints), 2);
    chk_eq("active_back1", 32'(active_level), 1);
    set_run(3'b011);
    tick(1);
    chk_eq("ack2_pend", 32'(pending), 0);
    set_run(3'b000);
    tick(1);
    chk_eq("active_idle", 32'(active_level), 0);

    // Masking holds the request pending without presenting it
    irq_mask = 3'b010;
    irq_src[1] = 1'b1;
    tick(3);
    irq_src[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      seen = seen | ints[1];
    end
    chk_eq("mask_hold", 32'(seen), 0);
    chk_eq("mask_pend", 32'(pending), 2);
    irq_mask = 3'b000;
    tick(1);
    chk_eq("unmask_int2", 32'(ints), 2);
    set_run(3'b010);
    tick(1);
    set_run(3'b000);
    tick(1);
    chk_eq("mask_retired", 32'(pending), 0);

    // Lost flag on double request, clear, and rise coincident with ack
    irq_src[0] = 1'b1; tick(3);
    irq_src[0] = 1'b0; tick(3);
    irq_src[0] = 1'b1; tick(3);
    irq_src[0] = 1'b0; tick(1);
    chk_eq("lost_set", 32'(lost), 1);
    chk_eq("lost_pend", 32'(pending), 1);
    lost_clr = 1'b1;
    tick(1);
    lost_clr = 1'b0;
    chk_eq("lost_clr", 32'(lost), 0);
    irq_src[0] = 1'b1;
    tick(2);
    set_run(3'b001);
    tick(1);
    irq_src[0] = 1'b0;
    chk_eq("rise_ack_pend", 32'(pending), 1);
    chk_eq("rise_ack_lost", 32'(lost), 0);
    chk_eq("rise_ack_ints", 32'(ints), 0);
    set_run(3'b000);
    tick(1);
    chk_eq("re_present", 32'(ints), 1);
    set_run(3'b001);
    tick(1);
    set_run(3'b000);
    tick(1);
    chk_eq("re_retired", 32'(pending), 0);

    // Serviced counter: 1+1+2+1+1 completions
    sb_push(6);
    pulse_done(3'b001);
    pulse_done(3'b010);
    pulse_done(3'b101);
    pulse_done(3'b100);
    pulse_done(3'b001);
    sb_pop_check("svc_cnt", 32'(serviced_cnt));
    for (int i = 0; i < 15; i++) pulse_done4();
    chk_eq("cnt4_pre", 32'(serviced_cnt4), 15);
    pulse_done4();
    chk_eq("cnt4_wrap", 32'(serviced_cnt4), 0);

    // Unacknowledged level-2 request
    request_latency(1, "lat_int2_tmo");
`ifdef IRQ_TIMEOUT_EN
    sb_push(8);
    n = 0;
    while (!irq_timeout[1] && n < 30) begin
      tick(1);
      n++;
    end
    sb_pop_check("tmo_lat", 32'(n));
    chk_eq("tmo_flag", 32'(irq_timeout), 2);
    chk_eq("tmo_pend", 32'(pending), 0);
    tick(1);
    chk_eq("tmo_ints", 32'(ints), 0);
`else
    n = 0;
    tick(20);
    chk_eq("no_tmo_ints", 32'(ints), 2);
    chk_eq("no_tmo_flag", 32'(irq_timeout), 0);
    chk_eq("no_tmo_pend", 32'(pending), 2);
    set_run(3'b010);
    tick(1);
    set_run(3'b000);
    tick(1);
`endif

    // Asynchronous reset in mid-service
    request_latency(2, "lat_int3_rst");
    irq_src[2] = 1'b1;
    #2;
    clr_n = 1'b0;
    #1;
    chk_eq("arst_ints", 32'(ints), 0);
    chk_eq("arst_pend", 32'(pending), 0);
    chk_eq("arst_cnt", 32'(serviced_cnt), 0);
    chk_eq("arst_active", 32'(active_level), 0);
    chk_eq("arst_lost", 32'(lost), 0);
    chk_eq("arst_tmo", 32'(irq_timeout), 0);
    irq_src[2] = 1'b0;
    tick(2);
    clr_n = 1'b1;
    tick(10);
    chk_eq("post_rst_ints", 32'(ints), 0);
    chk_eq("post_rst_pend", 32'(pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_request_ctrl.md
Name: irq_request_ctrl

Overview:
- Initiator side of the CPU interrupt handshake: turns three raw external request lines (board buttons/peripherals) into the level-held interrupt1/2/3 requests consumed by the PC/interrupt-sequencing logic.
- Watches the returned interruptN_running/interruptN_done feedback to acknowledge and retire requests.
- Sits between board I/O and the PC block.
- Provides synchronisation, edge capture, pending latching, masking, nesting-aware gating, lost-request flags and a serviced-interrupt counter.

Parameters:
- SYNC_STAGES, 2, flops per raw-input synchroniser chain (>=2).
- CNT_W, 16, width of the serviced-interrupt counter.
- TIMEOUT_CYC, 1024, cycles a request may stay unacknowledged before the timeout flag sets (optional feature only).

Ports:
- clk  in  1  system clock, all logic on posedge.
- clr_n  in  1  asynchronous active-low reset.
- irq_src  in  3  raw asynchronous request lines; bit0 = level1 … bit2 = level3; rising edge = request.
- irq_mask  in  3  1 = level masked (request held pending, not presented).
- lost_clr  in  1  synchronous pulse, clears lost flags.
- interrupt1_running, interrupt2_running, interrupt3_running  in  1 each  from PC: level in service.
- interrupt1_done, interrupt2_done, interrupt3_done  in  1 each  from PC: one-cycle service-complete pulses.
- interrupt1, interrupt2, interrupt3  out  1 each  registered request levels to PC.
- pending  out  3  latched pending requests.
- lost  out  3  sticky: edge arrived while same level already pending.
- active_level  out  2  registered highest running level (0 = user code, 1..3).
- serviced_cnt  out  CNT_W  total completed interrupts.
- irq_timeout  out  3  sticky timeout flags (optional feature; tied 0 when absent).

Behaviour:
- Reset: clr_n low asynchronously clears synchronisers, edge registers, pending, lost, interruptN, active_level, serviced_cnt, irq_timeout and timeout counters to 0.
  - Reset mid-service drops all pending requests; no re-issue after release.
- Synchroniser: each irq_src bit passes SYNC_STAGES flops. A registered copy of the last stage gives rise = sync & ~sync_d.
- Acknowledge detect: register interruptN_running each cycle. ackN = running & ~running_d (rising edge).
- pending[N] next state, in this priority order:
  - rise: set to 1.
  - ackN without rise: clear to 0.
  - else: hold.
  - rise and ack in the same cycle leaves pending=1 (new request wins); lost not set.
- lost[N]: set when rise occurs while pending[N]=1 and no ackN that cycle. Cleared only by lost_clr or reset. Set beats clear on the same cycle.
- Request gating, registered one cycle after pending (priority 3 highest, matching PC nesting):
  - interrupt3 = pending[2] & ~irq_mask[2] & ~interrupt3_running.
  - interrupt2 = pending[1] & ~irq_mask[1] & ~interrupt2_running & ~interrupt3_running.
  - interrupt1 = pending[0] & ~irq_mask[0] & ~interrupt1_running & ~interrupt2_running & ~interrupt3_running.
- Latency: irq_src rising edge to interruptN high = SYNC_STAGES+2 cycles (4 at default). Ack to interruptN low = 1 cycle after running rises.
- Masking: a masked level keeps pending. Unmasking asserts interruptN on the next clock edge if still eligible. Masking asserts no clear.
- active_level: 3 if running3, else 2 if running2, else 1 if running1, else 0; registered.
- serviced_cnt: adds popcount of the three done pulses each cycle; wraps modulo 2^CNT_W without saturation.
- A done pulse does not touch pending; a request for the same level arriving during service is re-presented after running falls.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- Defined:
  - Per level, a counter runs while interruptN=1 and resets to 0 when interruptN=0.
  - On reaching TIMEOUT_CYC, irq_timeout[N] sets (sticky, cleared by lost_clr or reset) and pending[N] is force-cleared so a hung level cannot block lower ones.
- Undefined: no counters; irq_timeout tied to 3'b000; pending is cleared only by ack.

Test Plan:
- Reset, pulse irq_src[0] high at cycle 10, running all 0 -> interrupt1=1 at cycle 14, pending=3'b001. Raise interrupt1_running at cycle 20 -> interrupt1=0 and pending=0 at cycle 21, active_level=1.
- Level1 running, pulse irq_src[2] -> interrupt3 asserts (nesting allowed). Pulse irq_src[1] while running3=1 -> interrupt2 stays 0 until running3 falls, then asserts next cycle.
- irq_mask=3'b010, pulse irq_src[1] -> pending[1]=1 and interrupt2=0 for 50 cycles. Clear mask -> interrupt2=1 on next edge.
- Two irq_src[0] rising edges before any ack -> lost=3'b001. lost_clr pulse -> lost=0. Rise coincident with ack -> pending stays 1, lost stays 0.
- Issue 5 done pulses (one with done1 and done3 together) -> serviced_cnt=6. With CNT_W=4, preload 15 and one done -> wraps to 0.
- IRQ_TIMEOUT_EN, TIMEOUT_CYC=8, request level2 with running never raised -> irq_timeout=3'b010 after 8 cycles high, pending[1]=0, interrupt2=0. Assert clr_n low mid-run -> all outputs 0 immediately.
